// File: rtl/output_mux_if.sv
// Bundle between the project slots, the shared pad bus and whoever drives the select.
// The master side drives the select and project buses. The slave side is the mux.
interface output_mux_if #(
    parameter int SEL_BITS    = 2,
    parameter int OUTPUT_BITS = 8
);
    logic [SEL_BITS-1:0]      sel;
    logic [4*OUTPUT_BITS-1:0] proj_out;
    logic [4*OUTPUT_BITS-1:0] proj_oe;
    logic [OUTPUT_BITS-1:0]   out;
    logic [OUTPUT_BITS-1:0]   oe;
    logic [SEL_BITS-1:0]      active_sel;
    logic                     busy;
    logic                     switched;

    modport master (
        output sel, proj_out, proj_oe,
        input  out, oe, active_sel, busy, switched
    );

    modport slave (
        input  sel, proj_out, proj_oe,
        output out, oe, active_sel, busy, switched
    );
endinterface

// File: rtl/output_mux.sv
// Return-path project mux: drives the shared pad bus from one of four project
// slots. Switching is break-before-make. The bus is blanked for GUARD_CYCLES
// cycles before the new slot is connected. A select that changes during the
// blanking restarts the guard interval.
module output_mux #(
    parameter int SEL_BITS     = 2,
    parameter int OUTPUT_BITS  = 8,
    parameter int GUARD_CYCLES = 4   // 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    output_mux_if.slave bus
);
    typedef enum logic {GUARD = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES);

    state_t                          state, state_d;
    logic [7:0]                      cnt, cnt_d;
    logic [SEL_BITS-1:0]             sel_q, tgt, tgt_d, act_q, act_d;
    logic [OUTPUT_BITS-1:0]          out_q, oe_q, out_d, oe_d;
    logic                            busy_q, sw_q, sw_d;

    // The packed view matches the flat packing: slot n = bits [(n+1)*W-1 : n*W]
    logic [3:0][OUTPUT_BITS-1:0]     slot_out, slot_oe;
    logic [SEL_BITS-1:0]             src;
    logic [31:0]                     src_ext;
    logic [OUTPUT_BITS-1:0]          src_out, src_oe;

    assign slot_out = bus.proj_out;
    assign slot_oe  = bus.proj_oe;

    // The data source is the connected slot while ACTIVE. It is the pending target while GUARD,
    // so the ACTIVE entry edge already carries the new project's data.
    assign src     = (state == ACTIVE) ? act_q : tgt;
    assign src_ext = {{(32-SEL_BITS){1'b0}}, src};

    // Codes >= 4 select no project: zero bus
    always_comb begin
        src_out = '0;
        src_oe  = '0;
        if (src_ext < 32'd4) begin
            src_out = slot_out[src_ext[1:0]];
            src_oe  = slot_oe[src_ext[1:0]];
        end
    end

    // Next-state and registered-output logic. The bus defaults to blanked.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tgt_d   = tgt;
        act_d   = act_q;
        out_d   = '0;
        oe_d    = '0;
        sw_d    = 1'b0;
        case (state)
            ACTIVE: begin
                if (sel_q != act_q) begin
                    state_d = GUARD;
                    tgt_d   = sel_q;
                    cnt_d   = GUARD_LD;
                end else begin
                    out_d = src_out;
                    oe_d  = src_oe;
                end
            end
            GUARD: begin
                if (sel_q != tgt) begin
                    // The select moved during the guard: the full interval starts again.
                    tgt_d = sel_q;
                    cnt_d = GUARD_LD;
                end else if (cnt == 8'd1) begin
                    state_d = ACTIVE;
                    act_d   = tgt;
                    sw_d    = 1'b1;
                    out_d   = src_out;
                    oe_d    = src_oe;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: state_d = GUARD;
        endcase
    end

    // State, select latch and output registers. Reset has priority over every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= GUARD;
            cnt    <= GUARD_LD;
            sel_q  <= '0;
            tgt    <= '0;
            act_q  <= '0;
            out_q  <= '0;
            oe_q   <= '0;
            busy_q <= 1'b1;
            sw_q   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            sel_q  <= bus.sel;
            tgt    <= tgt_d;
            act_q  <= act_d;
            out_q  <= out_d;
            oe_q   <= oe_d;
            busy_q <= (state_d == GUARD);
            sw_q   <= sw_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.oe         = oe_q;
    assign bus.active_sel = act_q;
    assign bus.busy       = busy_q;
    assign bus.switched   = sw_q;
endmodule

// File: tb/tb_output_mux.sv
// Directed bench for output_mux (SEL_BITS=3 so that out-of-range codes can be exercised).
module tb_output_mux;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    output_mux_if #(.SEL_BITS(3), .OUTPUT_BITS(8)) bus ();

    output_mux #(.SEL_BITS(3), .OUTPUT_BITS(8), .GUARD_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [7:0] o, input logic [7:0] e,
                           input logic [2:0] a, input logic b, input logic s);
        chk({tag, ".out"},        32'(bus.out),        32'(o));
        chk({tag, ".oe"},         32'(bus.oe),         32'(e));
        chk({tag, ".active_sel"}, 32'(bus.active_sel), 32'(a));
        chk({tag, ".busy"},       32'(bus.busy),       32'(b));
        chk({tag, ".switched"},   32'(bus.switched),   32'(s));
    endtask

    // Blanked-bus check used during guard intervals.
    task automatic chk_guard(input string tag);
        chk({tag, ".out"},  32'(bus.out),  32'h0);
        chk({tag, ".oe"},   32'(bus.oe),   32'h0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'h1);
        chk({tag, ".sw"},   32'(bus.switched), 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.sel      = 3'd0;
        // slot3 | slot2 | slot1 | slot0
        bus.proj_out = {8'hC3, 8'h5A, 8'h99, 8'hA5};
        bus.proj_oe  = {8'hF0, 8'h0F, 8'h33, 8'hFF};

        // Reset then idle
        step();
        step();
        chk_bus("rst", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_guard($sformatf("idle_guard%0d", i));
        end
        step();
        chk_bus("idle_conn", 8'hA5, 8'hFF, 3'd0, 1'b0, 1'b1);
        step();
        chk_bus("idle_hold", 8'hA5, 8'hFF, 3'd0, 1'b0, 1'b0);

        // Data latency: one edge
        bus.proj_out[7:0] = 8'h3C;
        chk("lat_before", 32'(bus.out), 32'hA5);
        step();
        chk("lat_after", 32'(bus.out), 32'h3C);

        // Clean switch 0 -> 2
        bus.sel = 3'd2;
        step();                                   // E0: sel_q latches
        chk_bus("sw_e0", 8'h3C, 8'hFF, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_guard($sformatf("sw_guard%0d", i));
        end
        step();
        chk_bus("sw_conn", 8'h5A, 8'h0F, 3'd2, 1'b0, 1'b1);
        step();
        chk_bus("sw_hold", 8'h5A, 8'h0F, 3'd2, 1'b0, 1'b0);

        // Reselecting the same project: no guard, no glitch
        bus.sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bus($sformatf("same%0d", i), 8'h5A, 8'h0F, 3'd2, 1'b0, 1'b0);
        end

        // Guard restart: 2 -> 1, then -> 3 after two guard cycles
        bus.sel = 3'd1;
        step();                                   // E0
        chk("rs_e0.out", 32'(bus.out), 32'h5A);
        step();                                   // E1: GUARD, cnt=4
        chk_guard("rs_g1");
        step();                                   // E2: cnt=3
        chk_guard("rs_g2");
        bus.sel = 3'd3;
        for (int i = 0; i < 5; i++) begin         // E3..E7 (restart at E4)
            step();
            chk_guard($sformatf("rs_guard%0d", i));
        end
        step();                                   // E8
        chk_bus("rs_conn", 8'hC3, 8'hF0, 3'd3, 1'b0, 1'b1);

        // Invalid select code: guard, then ACTIVE with a zero bus
        bus.sel = 3'd5;
        step();
        chk("inv_e0.out", 32'(bus.out), 32'hC3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_guard($sformatf("inv_guard%0d", i));
        end
        step();
        chk_bus("inv_conn", 8'h00, 8'h00, 3'd5, 1'b0, 1'b1);
        step();
        chk_bus("inv_hold", 8'h00, 8'h00, 3'd5, 1'b0, 1'b0);

        // Reset mid-guard (cnt=2), then reconnect to project 1
        bus.sel = 3'd1;
        step();                                   // E0
        step();                                   // E1 cnt=4
        step();                                   // E2 cnt=3
        step();                                   // E3 cnt=2
        chk_guard("mr_pre");
        rst_n = 1'b0;
        step();
        chk_bus("mr_rst", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        rst_n = 1'b1;
        // sel_q resets to 0 and catches up one edge later, restarting the guard
        for (int i = 0; i < 5; i++) begin
            step();
            chk_guard($sformatf("mr_guard%0d", i));
        end
        step();
        chk_bus("mr_conn", 8'h99, 8'h33, 3'd1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
